// File: rtl/cdc_src_pkg.sv
// Shared types and constants for the cdc_src_hold source-side transfer stage.
//   state_e    : FSM encoding (IDLE=0, HOLD=1, GAP=2)
//   *_MIN/MAX  : legal ranges of the HOLD_CYC and GAP_CYC parameters
//   TXC_W      : width of the accepted-word counter tx_cnt
package cdc_src_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned HOLD_MIN = 1;
  localparam int unsigned HOLD_MAX = 255;
  localparam int unsigned GAP_MIN  = 1;
  localparam int unsigned GAP_MAX  = 255;
  localparam int unsigned TXC_W    = 8;

  // Largest value the hold/gap down-counter must represent.
  function automatic int unsigned cnt_need(input int unsigned hold_cyc,
                                           input int unsigned gap_cyc);
    return ((hold_cyc > gap_cyc) ? hold_cyc : gap_cyc) - 1;
  endfunction

endpackage

// File: rtl/cdc_src_hold_if.sv
// Valid/ready word stream into cdc_src_hold.
//   in_data  : word to transfer
//   in_valid : in_data valid
//   in_ready : stage can accept (driven by the stage)
// master = word source, slave = cdc_src_hold.
interface cdc_src_hold_if #(
  parameter int unsigned DW = 4
) ();

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous level input
//   q     : synchronized level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdc_src_hold.sv
// Source-side (clk_a) stage for the clk_a->clk_b word transfer block.
// Registers each accepted word, holds it on data_out with data_en high for
// HOLD_CYC cycles, then keeps data_out stable for a GAP_CYC guard gap.
//   clk_a    : source clock
//   arstn    : asynchronous active-low reset
//   strm     : valid/ready input stream (in_data, in_valid, in_ready)
//   data_out : registered word to transfer block
//   data_en  : registered enable to transfer block
//   busy     : high whenever not IDLE
//   tx_cnt   : accepted-word count, wraps
// Optional macro CDC_SRC_ACK_EN adds input ack_b (clk_b echo of the
// synchronized enable) and turns the counters into minimums of a four-phase
// handshake.
module cdc_src_hold
  import cdc_src_pkg::*;
#(
  parameter int unsigned DW       = 4,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned GAP_CYC  = 2,
  parameter int unsigned CW       = 8
) (
  input  logic             clk_a,
  input  logic             arstn,
  cdc_src_hold_if.slave    strm,
  output logic [DW-1:0]    data_out,
  output logic             data_en,
  output logic             busy,
  output logic [TXC_W-1:0] tx_cnt
`ifdef CDC_SRC_ACK_EN
  ,
  input  logic             ack_b
`endif
);

  // Elaboration-time parameter range checks.
  if (HOLD_CYC < HOLD_MIN || HOLD_CYC > HOLD_MAX) begin : g_bad_hold
    $fatal(1, "cdc_src_hold: HOLD_CYC=%0d outside 1..255", HOLD_CYC);
  end
  if (GAP_CYC < GAP_MIN || GAP_CYC > GAP_MAX) begin : g_bad_gap
    $fatal(1, "cdc_src_hold: GAP_CYC=%0d outside 1..255", GAP_CYC);
  end
  if (CW == 0 || (CW < 32 && (cnt_need(HOLD_CYC, GAP_CYC) >> CW) != 0)) begin : g_bad_cw
    $fatal(1, "cdc_src_hold: CW=%0d too narrow", CW);
  end

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

  state_e           state,    state_nxt;
  logic [CW-1:0]    cnt,      cnt_nxt;
  logic [DW-1:0]    data_nxt;
  logic             en_nxt;
  logic [TXC_W-1:0] tx_nxt;

  // HOLD may exit / GAP may count only when these allow it.
  logic hold_exit_ok;
  logic gap_run_ok;

`ifdef CDC_SRC_ACK_EN
  logic ack_s;

  sync_2ff u_ack_sync (
    .clk   (clk_a),
    .rst_n (arstn),
    .d     (ack_b),
    .q     (ack_s)
  );

  assign hold_exit_ok = ack_s;
  assign gap_run_ok   = ~ack_s;
`else
  assign hold_exit_ok = 1'b1;
  assign gap_run_ok   = 1'b1;
`endif

  // State and datapath registers.
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      cnt      <= '0;
      data_out <= '0;
      data_en  <= 1'b0;
      tx_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      data_out <= data_nxt;
      data_en  <= en_nxt;
      tx_cnt   <= tx_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_out;
    en_nxt    = data_en;
    tx_nxt    = tx_cnt;
    unique case (state)
      IDLE: begin
        if (strm.in_valid) begin
          data_nxt  = strm.in_data;
          en_nxt    = 1'b1;
          cnt_nxt   = HOLD_LD;
          tx_nxt    = tx_cnt + TXC_W'(1);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Counter parks at zero while waiting for the ack, if any.
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (hold_exit_ok) begin
          en_nxt    = 1'b0;
          cnt_nxt   = GAP_LD;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_run_ok) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign strm.in_ready = (state == IDLE);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_cdc_src_hold.sv
// Directed self-checking bench for cdc_src_hold (default parameters).
// With CDC_SRC_ACK_EN defined, the ack handshake sequence replaces the
// counter-only sequences.
module tb_cdc_src_hold;

  logic       clk_a = 1'b0;
  logic       arstn = 1'b0;
  logic [3:0] data_out;
  logic       data_en;
  logic       busy;
  logic [7:0] tx_cnt;
`ifdef CDC_SRC_ACK_EN
  logic       ack_b = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_a = ~clk_a;

  cdc_src_hold_if #(.DW(4)) bus ();

  cdc_src_hold #(
    .DW       (4),
    .HOLD_CYC (4),
    .GAP_CYC  (2),
    .CW       (8)
  ) dut (
    .clk_a    (clk_a),
    .arstn    (arstn),
    .strm     (bus),
    .data_out (data_out),
    .data_en  (data_en),
    .busy     (busy),
    .tx_cnt   (tx_cnt)
`ifdef CDC_SRC_ACK_EN
    ,
    .ack_b    (ack_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;

    // Reset then idle.
    repeat (3) tick();
    arstn = 1'b1;
    tick();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_data_en",  32'(data_en),  32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_tx_cnt",   32'(tx_cnt),   32'h0);

`ifndef CDC_SRC_ACK_EN
    // Single word: 4 cycles enable, 2 cycles gap, ready again at sample 6.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hA;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("single_en_%0d", k),    32'(data_en),      32'(k < 4));
      chk($sformatf("single_rdy_%0d", k),   32'(bus.in_ready), 32'(k == 6));
      chk($sformatf("single_data_%0d", k),  32'(data_out),     32'hA);
      tick();
    end
    chk("single_tx_cnt", 32'(tx_cnt), 32'h1);

    // Back-to-back with in_data toggling while not ready.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h3;
    tick();
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("b2b_data_%0d", k), 32'(data_out),     32'h3);
      chk($sformatf("b2b_rdy_%0d", k),  32'(bus.in_ready), 32'(k == 6));
      bus.in_data = (k == 6) ? 4'h5 : ((k % 2) == 1) ? 4'hF : 4'h0;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("b2b_second_data", 32'(data_out), 32'h5);
    chk("b2b_second_en",   32'(data_en),  32'h1);
    chk("b2b_tx_cnt",      32'(tx_cnt),   32'h3);
    repeat (7) tick();
    chk("b2b_idle_rdy", 32'(bus.in_ready), 32'h1);
    chk("b2b_idle_en",  32'(data_en),      32'h0);

    // Async reset in the second HOLD cycle.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h9;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("arst_pre_en",   32'(data_en),  32'h1);
    chk("arst_pre_data", 32'(data_out), 32'h9);
    #2;
    arstn = 1'b0;
    #1;
    chk("arst_en",     32'(data_en),      32'h0);
    chk("arst_data",   32'(data_out),     32'h0);
    chk("arst_tx_cnt", 32'(tx_cnt),       32'h0);
    chk("arst_rdy",    32'(bus.in_ready), 32'h1);
    #2;
    arstn = 1'b1;
    tick();
    chk("arst_post_rdy",  32'(bus.in_ready), 32'h1);
    chk("arst_post_busy", 32'(busy),         32'h0);
    chk("arst_post_en",   32'(data_en),      32'h0);

    // tx_cnt wraps 255 -> 0 with in_valid held high.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h6;
    tick();
    chk("wrap_first", 32'(tx_cnt), 32'h1);
    repeat (254) repeat (7) tick();
    chk("wrap_255", 32'(tx_cnt), 32'hFF);
    repeat (7) tick();
    chk("wrap_0", 32'(tx_cnt), 32'h0);
    bus.in_valid = 1'b0;
    repeat (8) tick();
    chk("wrap_idle_rdy", 32'(bus.in_ready), 32'h1);
`else
    // Four-phase handshake: enable held until ack_s rises.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hA;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("ack_wait_en_%0d", k),  32'(data_en),      32'h1);
      chk($sformatf("ack_wait_rdy_%0d", k), 32'(bus.in_ready), 32'h0);
      tick();
    end
    ack_b = 1'b1;
    tick();
    chk("ack_rise_en_1", 32'(data_en), 32'h1);
    tick();
    chk("ack_rise_en_2", 32'(data_en), 32'h1);
    tick();
    chk("ack_rise_en_3", 32'(data_en),  32'h0);
    chk("ack_data",      32'(data_out), 32'hA);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ack_gap_rdy_%0d", k), 32'(bus.in_ready), 32'h0);
      tick();
    end
    ack_b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("ack_fall_rdy_%0d", k), 32'(bus.in_ready), 32'(k == 4));
      chk($sformatf("ack_fall_en_%0d", k),  32'(data_en),      32'h0);
    end
    chk("ack_tx_cnt", 32'(tx_cnt),   32'h1);
    chk("ack_data_2", 32'(data_out), 32'hA);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
